// File: rtl/line_fifo.sv
// Single-clock line buffer FIFO with word count, line-ready threshold and sticky error flags.
// Storage is a simple dual-port RAM; the read word is registered into q.
module line_fifo #(
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 1024,
    parameter int LINE_LEN = 640,
    localparam int UW      = $clog2(DEPTH + 1),
    localparam int PW      = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,
    input  logic              wr_req,
    input  logic [DATA_W-1:0] data,
    output logic              full,
    input  logic              rd_req,
    output logic [DATA_W-1:0] q,
    output logic              q_valid,
    output logic              empty,
    output logic [UW-1:0]     used,
    output logic              line_ready,
    output logic              overflow,
    output logic              underflow
);

    logic [DATA_W-1:0] mem [DEPTH];

    logic [PW-1:0]     head_q, head_d;
    logic [PW-1:0]     tail_q, tail_d;
    logic [UW-1:0]     used_q, used_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              q_valid_q, q_valid_d;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;

    logic wr_acc;
    logic rd_acc;
    logic mem_we;

    assign full       = (used_q == UW'(DEPTH));
    assign empty      = (used_q == '0);
    assign line_ready = (used_q >= UW'(LINE_LEN));

    assign wr_acc = wr_req && !full;
    assign rd_acc = rd_req && !empty;
    // Flush and reset both suppress the RAM write so nothing lands behind the cleared pointers.
    assign mem_we = wr_acc && !flush && !reset;

    always_comb begin
        head_d      = head_q;
        tail_d      = tail_q;
        used_d      = used_q;
        dout_d      = dout_q;
        q_valid_d   = 1'b0;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;

        if (flush) begin
            head_d      = '0;
            tail_d      = '0;
            used_d      = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            if (wr_acc) begin
                head_d = (head_q == PW'(DEPTH - 1)) ? '0 : head_q + PW'(1);
            end
            if (rd_acc) begin
                tail_d    = (tail_q == PW'(DEPTH - 1)) ? '0 : tail_q + PW'(1);
                dout_d    = mem[tail_q];
                q_valid_d = 1'b1;
            end
            if (wr_acc && !rd_acc) begin
                used_d = used_q + UW'(1);
            end else if (rd_acc && !wr_acc) begin
                used_d = used_q - UW'(1);
            end
            if (wr_req && full) begin
                overflow_d = 1'b1;
            end
            if (rd_req && empty) begin
                underflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            head_q      <= '0;
            tail_q      <= '0;
            used_q      <= '0;
            dout_q      <= '0;
            q_valid_q   <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            head_q      <= head_d;
            tail_q      <= tail_d;
            used_q      <= used_d;
            dout_q      <= dout_d;
            q_valid_q   <= q_valid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem[head_q] <= data;
        end
    end

    assign q         = dout_q;
    assign q_valid   = q_valid_q;
    assign used      = used_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule

// File: tb/tb_line_fifo.sv
// Directed bench for line_fifo at DATA_W=8, DEPTH=8, LINE_LEN=4 with hand-computed expectations.
module tb_line_fifo;

    localparam int DATA_W   = 8;
    localparam int DEPTH    = 8;
    localparam int LINE_LEN = 4;
    localparam int UW       = $clog2(DEPTH + 1);

    logic              clock = 1'b0;
    logic              reset, flush, wr_req, rd_req;
    logic [DATA_W-1:0] data;
    logic              full, q_valid, empty, line_ready, overflow, underflow;
    logic [DATA_W-1:0] q;
    logic [UW-1:0]     used;

    int n_checks = 0;
    int n_errors = 0;

    line_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .LINE_LEN(LINE_LEN)) dut (
        .clock(clock), .reset(reset), .flush(flush),
        .wr_req(wr_req), .data(data), .full(full),
        .rd_req(rd_req), .q(q), .q_valid(q_valid),
        .empty(empty), .used(used), .line_ready(line_ready),
        .overflow(overflow), .underflow(underflow)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the edge; outputs are sampled at the same point.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        wr_req = 1'b0; rd_req = 1'b0; flush = 1'b0; reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; wr_req = 1'b0; rd_req = 1'b0; data = '0;
        step(); step();
        idle();
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_used", used, 0);
        check("rst_q", q, 0);
        check("rst_qv", q_valid, 0);
        check("rst_lr", line_ready, 0);
        check("rst_ovf", overflow, 0);
        check("rst_unf", underflow, 0);

        // Four writes, then four reads
        for (int i = 0; i < 4; i++) begin
            wr_req = 1'b1; data = 8'h10 + 8'(i);
            step();
            check("w4_used", used, i + 1);
            check("w4_lr", line_ready, (i + 1 >= LINE_LEN) ? 1 : 0);
        end
        wr_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rd_req = 1'b1;
            step();
            check("r4_q", q, 8'h10 + i);
            check("r4_qv", q_valid, 1);
            check("r4_used", used, 3 - i);
        end
        rd_req = 1'b0;
        step();
        check("r4_qv_idle", q_valid, 0);
        check("r4_q_hold", q, 8'h13);
        check("r4_empty", empty, 1);

        // Fill past full
        for (int i = 0; i < 9; i++) begin
            wr_req = 1'b1; data = 8'(i);
            step();
            if (i == 6) check("f_notfull", full, 0);
            if (i == 7) begin
                check("f_full", full, 1);
                check("f_ovf0", overflow, 0);
            end
            if (i == 8) begin
                check("f_ovf", overflow, 1);
                check("f_used", used, 8);
            end
        end
        wr_req = 1'b0;
        for (int i = 0; i < 8; i++) begin
            rd_req = 1'b1;
            step();
            check("f_drain_q", q, i);
        end
        rd_req = 1'b0;
        step();
        check("f_empty", empty, 1);
        check("f_ovf_sticky", overflow, 1);
        check("f_unf", underflow, 0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("f_flush_ovf", overflow, 0);

        // Wrap across DEPTH-1
        for (int i = 0; i < 6; i++) begin
            wr_req = 1'b1; data = 8'h50 + 8'(i); step();
        end
        wr_req = 1'b0;
        for (int i = 0; i < 6; i++) begin
            rd_req = 1'b1; step();
            check("wr1_q", q, 8'h50 + i);
        end
        rd_req = 1'b0;
        for (int i = 0; i < 6; i++) begin
            wr_req = 1'b1; data = 8'hA0 + 8'(i); step();
        end
        wr_req = 1'b0;
        check("wr2_used", used, 6);
        for (int i = 0; i < 6; i++) begin
            rd_req = 1'b1; step();
            check("wr2_q", q, 8'hA0 + i);
        end
        rd_req = 1'b0;
        step();
        check("wr2_empty", empty, 1);

        // Simultaneous requests while full
        for (int i = 0; i < 8; i++) begin
            wr_req = 1'b1; data = 8'h30 + 8'(i); step();
        end
        wr_req = 1'b1; rd_req = 1'b1; data = 8'hEE;
        step();
        check("sf_q", q, 8'h30);
        check("sf_qv", q_valid, 1);
        check("sf_used", used, 7);
        check("sf_ovf", overflow, 1);
        wr_req = 1'b0;
        for (int i = 1; i < 8; i++) begin
            step();
            check("sf_drain_q", q, 8'h30 + i);
        end
        rd_req = 1'b0;
        step();
        check("sf_empty", empty, 1);

        // Simultaneous requests while empty
        wr_req = 1'b1; rd_req = 1'b1; data = 8'h77;
        step();
        check("se_used", used, 1);
        check("se_unf", underflow, 1);
        check("se_qv", q_valid, 0);
        check("se_q_hold", q, 8'h37);

        // Simultaneous accept with one word stored
        data = 8'h42;
        step();
        check("s1_q", q, 8'h77);
        check("s1_qv", q_valid, 1);
        check("s1_used", used, 1);
        wr_req = 1'b0;
        step();
        check("s1_q2", q, 8'h42);
        check("s1_empty", empty, 1);
        rd_req = 1'b0;
        step();

        // Flush with a concurrent write
        for (int i = 0; i < 5; i++) begin
            wr_req = 1'b1; data = 8'hC0 + 8'(i); step();
        end
        check("fl_used5", used, 5);
        check("fl_lr_pre", line_ready, 1);
        flush = 1'b1; wr_req = 1'b1; data = 8'hFF;
        step();
        idle();
        check("fl_used", used, 0);
        check("fl_empty", empty, 1);
        check("fl_lr", line_ready, 0);
        check("fl_ovf", overflow, 0);
        check("fl_unf", underflow, 0);
        check("fl_q_hold", q, 8'h42);
        wr_req = 1'b1; data = 8'h99; step();
        wr_req = 1'b0; rd_req = 1'b1; step();
        rd_req = 1'b0;
        check("fl_after_q", q, 8'h99);

        // Reset with three words stored and a read in flight
        for (int i = 0; i < 3; i++) begin
            wr_req = 1'b1; data = 8'h61 + 8'(i); step();
        end
        wr_req = 1'b1; rd_req = 1'b1; reset = 1'b1; data = 8'h55;
        step();
        idle();
        check("rs_q", q, 0);
        check("rs_qv", q_valid, 0);
        check("rs_used", used, 0);
        check("rs_empty", empty, 1);
        rd_req = 1'b1;
        step();
        rd_req = 1'b0;
        check("rs_unf", underflow, 1);
        check("rs_qv2", q_valid, 0);
        check("rs_used2", used, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
